// File: rtl/complement_pipe_pkg.sv
// Shared mode encodings, default lane width and lane-slice helper for complement_pipe.
// COMPLEMENT_PIPE_SAT_EN (see complement_lane) selects saturating overflow.
package complement_pipe_pkg;

    localparam logic COMP_MODE_SM2TC = 1'b0;
    localparam logic COMP_MODE_TC2SM = 1'b1;

    localparam int SIGWIDTH   = 11;
    localparam int LOW_EXPAND = 1;
    localparam int LANE_W_DEF = SIGWIDTH + 4 + LOW_EXPAND;

endpackage

`define COMP_LANE(vec, idx, w) vec[(idx)*(w) +: (w)]

// File: rtl/complement_pipe_if.sv
// Beat handshake bundle for complement_pipe: upstream beat in, converted beat out.
// master drives beats into the pipe and consumes results; slave is the pipe.
interface complement_pipe_if #(
    parameter int LANES  = 4,
    parameter int LANE_W = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_mode;
    logic [LANES-1:0]        in_sign;
    logic [LANES*LANE_W-1:0] in_num;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*LANE_W-1:0] out_num;
    logic [LANES-1:0]        out_ovf;

    modport master (
        output in_valid, in_mode, in_sign, in_num, out_ready,
        input  in_ready, out_valid, out_num, out_ovf
    );

    modport slave (
        input  in_valid, in_mode, in_sign, in_num, out_ready,
        output in_ready, out_valid, out_num, out_ovf
    );
endinterface

// File: rtl/complement_pipe_lane.sv
// Single-lane combinational convert for stage 2 of complement_pipe.
// COMPLEMENT_PIPE_SAT_EN: saturate the most negative 2C input instead of wrapping.
module complement_lane
    import complement_pipe_pkg::*;
#(
    parameter int LANE_W = 16
) (
    input  logic              mode,
    input  logic              sign,
    input  logic              zero,
    input  logic              neg,
    input  logic [LANE_W-2:0] low,
    output logic [LANE_W-1:0] res,
    output logic              ovf
);
    localparam int LW = LANE_W - 1;
    typedef logic [LW-1:0] low_t;

    low_t mag;
    logic big;

    always_comb begin
        mag = neg ? low_t'(~low + low_t'(1)) : low;
        big = (mode == COMP_MODE_TC2SM) && neg && (low == '0);
        res = {sign, mag};
        ovf = 1'b0;
        if (zero) begin
            res = '0;
        end else if (big) begin
`ifdef COMPLEMENT_PIPE_SAT_EN
            res = {sign, {LW{1'b1}}};
            ovf = 1'b1;
`else
            // magnitude already wrapped to zero; only the sign survives
            res = {sign, {LW{1'b0}}};
`endif
        end
    end
endmodule

// File: rtl/complement_pipe.sv
// Two-stage sign-magnitude <-> two's-complement lane converter with valid/ready.
// COMPLEMENT_PIPE_SAT_EN enables saturation and overflow flags on 2C->SM.
module complement_pipe
    import complement_pipe_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int LANE_W = LANE_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    complement_pipe_if.slave     bus
);
    typedef logic [LANE_W-2:0] low_t;

    logic adv;

    logic [LANES-1:0] d_zero;
    logic [LANES-1:0] d_neg;
    logic [LANES-1:0] d_osign;
    low_t [LANES-1:0] d_low;

    logic             s1_valid;
    logic             s1_mode;
    logic [LANES-1:0] s1_zero;
    logic [LANES-1:0] s1_neg;
    logic [LANES-1:0] s1_osign;
    low_t [LANES-1:0] s1_low;

    logic [LANES*LANE_W-1:0] lane_res;
    logic [LANES-1:0]        lane_ovf;

    logic                    out_valid_q;
    logic [LANES*LANE_W-1:0] out_num_q;
    logic [LANES-1:0]        out_ovf_q;

    assign adv           = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.out_num   = out_num_q;
    assign bus.out_ovf   = out_ovf_q;

    always_comb begin
        d_zero  = '0;
        d_neg   = '0;
        d_osign = '0;
        d_low   = '0;
        for (int i = 0; i < LANES; i++) begin
            d_zero[i] = (`COMP_LANE(bus.in_num, i, LANE_W) == '0);
            d_low[i]  = bus.in_num[i*LANE_W +: LANE_W-1];
            if (bus.in_mode == COMP_MODE_TC2SM) begin
                d_neg[i]   = bus.in_num[i*LANE_W + LANE_W-1];
                d_osign[i] = d_neg[i] ^ bus.in_sign[i];
            end else begin
                d_neg[i]   = bus.in_num[i*LANE_W + LANE_W-1] ^ bus.in_sign[i];
                d_osign[i] = d_neg[i];
            end
        end
    end

    // stage-1 payload needs no reset: it is qualified by s1_valid
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_mode  <= bus.in_mode;
            s1_zero  <= d_zero;
            s1_neg   <= d_neg;
            s1_osign <= d_osign;
            s1_low   <= d_low;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        complement_lane #(
            .LANE_W (LANE_W)
        ) u_lane (
            .mode (s1_mode),
            .sign (s1_osign[g]),
            .zero (s1_zero[g]),
            .neg  (s1_neg[g]),
            .low  (s1_low[g]),
            .res  (lane_res[g*LANE_W +: LANE_W]),
            .ovf  (lane_ovf[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            out_valid_q <= 1'b0;
            out_num_q   <= '0;
            out_ovf_q   <= '0;
        end else if (adv) begin
            s1_valid    <= bus.in_valid;
            out_valid_q <= s1_valid;
            out_num_q   <= lane_res;
            out_ovf_q   <= lane_ovf;
        end
    end
endmodule
